// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and J-immediate decode for the fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic        v2;
    } fetch_entry_t;
    function automatic logic [31:0] jimm_decode(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead pair queue with flush; an empty head reads as a NOP pair at pc 0.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  fetch_entry_t                  din,
    input  logic                          pop,
    output fetch_entry_t                  dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    fetch_entry_t mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign empty = count == '0;
    assign dout  = empty ? '{pc: 32'd0, instr1: NOP, instr2: NOP, v2: 1'b0} : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
    assert property (@(posedge clk) disable iff (rst) !(push && !flush && !pop && count == FULL));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: dual-issue PC/ROM fetch with credit-throttled pair queue and redirect flush.
// Optional JAL predecode redirect under FETCH_JAL_PREDECODE_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic              id_valid2,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_instr1,
    output logic [31:0]       id_instr2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] pc, pc_next, inflight_pc;
    logic inflight, fetch_go, capture, v2, v2_wrap, empty, pop;
    logic [CW-1:0] count;
    fetch_entry_t head;
    assign rom_addr = pc[ADDR_W+1:2];
    // Credits count both queued and in-flight pairs, so a push never meets a full queue.
    assign fetch_go = (count + CW'(inflight) < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign v2_wrap  = inflight_pc[ADDR_W+1:2] != '1;
    assign pop      = !empty && id_ready;
`ifdef FETCH_JAL_PREDECODE_EN
    logic squash, jal0, jal1, jal_redir;
    logic [31:0] jal_pc;
    assign capture   = inflight && !redirect_valid && !squash;
    assign jal0      = rom_instr1[6:0] == OPCODE_JAL;
    assign jal1      = v2_wrap && rom_instr2[6:0] == OPCODE_JAL;
    assign jal_redir = capture && (jal0 || jal1);
    assign jal_pc    = jal0 ? inflight_pc + jimm_decode(rom_instr1) : inflight_pc + 32'd4 + jimm_decode(rom_instr2);
    assign v2        = v2_wrap && !jal0;
    assign pc_next   = redirect_valid ? (redirect_pc & ~32'h3) : jal_redir ? jal_pc : fetch_go ? pc + 32'd8 : pc;
    // Only a fetch issued alongside the JAL capture is on the wrong path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) squash <= 1'b0;
        else squash <= jal_redir && fetch_go;
    end
`else
    assign capture = inflight && !redirect_valid;
    assign v2      = v2_wrap;
    assign pc_next = redirect_valid ? (redirect_pc & ~32'h3) : fetch_go ? pc + 32'd8 : pc;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            pc       <= pc_next;
            inflight <= fetch_go;
            if (fetch_go) inflight_pc <= pc;
        end
    end
    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (capture),
        .din   ('{pc: inflight_pc, instr1: rom_instr1, instr2: rom_instr2, v2: v2}),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .count (count)
    );
    assign id_valid  = !empty;
    assign id_valid2 = head.v2;
    assign id_pc     = head.pc;
    assign id_instr1 = head.instr1;
    assign id_instr2 = head.instr2;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks of fetch_stage against a pair-stream model.
module tb_fetch_stage;
    logic clk, rst, redirect_valid, id_ready, id_valid, id_valid2;
    logic [9:0] rom_addr, w_rom_addr;
    logic [31:0] rom_instr1, rom_instr2, redirect_pc, id_pc, id_instr1, id_instr2;
    logic [31:0] w_rom1, w_rom2, w_id_pc, w_id_instr1, w_id_instr2;
    logic w_id_valid, w_id_valid2;
    logic jal_mode;
    logic [31:0] exp_pc;
    int n_cmp, n_bad, n_hs;

    fetch_stage dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_valid2(id_valid2), .id_pc(id_pc), .id_instr1(id_instr1), .id_instr2(id_instr2)
    );
    fetch_stage #(.RESET_PC(32'h0000_0FFC)) dut_w (
        .clk(clk), .rst(rst), .rom_addr(w_rom_addr), .rom_instr1(w_rom1), .rom_instr2(w_rom2),
        .redirect_valid(1'b0), .redirect_pc(32'd0), .id_ready(1'b1),
        .id_valid(w_id_valid), .id_valid2(w_id_valid2), .id_pc(w_id_pc), .id_instr1(w_id_instr1), .id_instr2(w_id_instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
`ifdef FETCH_JAL_PREDECODE_EN
        return (jal_mode && a == 10'd4) ? 32'h0100_006F : {20'd0, a, 2'b00};
`else
        return {22'd0, a};
`endif
    endfunction

    always @(posedge clk) begin
        rom_instr1 <= rom_word(rom_addr);
        rom_instr2 <= rom_word(rom_addr + 10'd1);
        w_rom1     <= rom_word(w_rom_addr);
        w_rom2     <= rom_word(w_rom_addr + 10'd1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, score any handshake against the expected pc stream, advance.
    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
        id_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        if (!redir && rdy && id_valid) begin
            check("hs_pc", id_pc, exp_pc);
            check("hs_instr1", id_instr1, rom_word(exp_pc[11:2]));
            check("hs_instr2", id_instr2, rom_word(exp_pc[11:2] + 10'd1));
            check("hs_valid2", 32'(id_valid2), 32'(exp_pc[11:2] != 10'h3FF));
            exp_pc += 32'd8;
            n_hs++;
        end
        if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] held;
        int base, k;
        logic [31:0] r, rpc;
        n_cmp = 0; n_bad = 0; n_hs = 0;
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        jal_mode = 1'b0; exp_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_valid2", 32'(id_valid2), 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_instr1", id_instr1, 32'h13);
        check("rst_instr2", id_instr2, 32'h13);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_addr_w", 32'(w_rom_addr), 32'd1023);
        rst = 1'b0;
        id_ready = 1'b1;
        check("c0_addr", 32'(rom_addr), 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        check("c1_addr", 32'(rom_addr), 32'd2);
        check("c1_valid", 32'(id_valid), 32'd0);
        check("c1_addr_w", 32'(w_rom_addr), 32'd1);
        tick(1'b1, 1'b0, 32'd0);
        check("c2_addr", 32'(rom_addr), 32'd4);
        check("c2_valid", 32'(id_valid), 32'd1);
        check("c2_pc", id_pc, 32'd0);
        check("c2_instr1", id_instr1, rom_word(10'd0));
        check("c2_instr2", id_instr2, rom_word(10'd1));
        check("wrap_pc", w_id_pc, 32'h0000_0FFC);
        check("wrap_valid2", 32'(w_id_valid2), 32'd0);
        check("wrap_instr1", w_id_instr1, rom_word(10'd1023));
        check("wrap_instr2", w_id_instr2, rom_word(10'd0));
        tick(1'b1, 1'b0, 32'd0);
        check("wrap_next_pc", w_id_pc, 32'h0000_1004);
        check("wrap_next_valid2", 32'(w_id_valid2), 32'd1);
        check("wrap_next_instr1", w_id_instr1, rom_word(10'd1));
        base = n_hs;
        repeat (6) tick(1'b1, 1'b0, 32'd0);
        check("sustained", 32'(n_hs - base), 32'd6);
        repeat (5) tick(1'b0, 1'b0, 32'd0);
        held = rom_addr;
        repeat (5) tick(1'b0, 1'b0, 32'd0);
        check("stall_addr", 32'(rom_addr), 32'(held));
        check("stall_valid", 32'(id_valid), 32'd1);
        base = n_hs;
        repeat (8) tick(1'b1, 1'b0, 32'd0);
        check("resume", 32'(n_hs - base), 32'd8);
        repeat (6) tick(1'b0, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'h0000_0043);
        check("redir_drop", 32'(id_valid), 32'd0);
        k = 0;
        while (!id_valid && k < 4) begin
            tick(1'b0, 1'b0, 32'd0);
            k++;
        end
        check("redir_valid", 32'(id_valid), 32'd1);
        check("redir_pc", id_pc, 32'h0000_0040);
        check("redir_instr1", id_instr1, rom_word(10'd16));
        repeat (4) tick(1'b1, 1'b0, 32'd0);
        base = n_hs;
        repeat (400) begin
            r = $urandom;
            rpc = r[8] ? $urandom : 32'h0000_0FF0 + {28'd0, r[12:9]};
            tick(r[1:0] != 2'b00, r[7:3] == 5'd0, rpc);
        end
        check("rand_progress", 32'((n_hs - base) > 100), 32'd1);
        repeat (8) tick(1'b0, 1'b0, 32'd0);
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(id_valid), 32'd0);
        check("arst_valid2", 32'(id_valid2), 32'd0);
        check("arst_pc", id_pc, 32'd0);
        check("arst_instr1", id_instr1, 32'h13);
        check("arst_instr2", id_instr2, 32'h13);
        check("arst_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = '0;
        repeat (12) tick(1'b1, 1'b0, 32'd0);
`ifdef FETCH_JAL_PREDECODE_EN
        begin
            logic [31:0] pcs[$];
            logic v2_at10;
            int idx;
            bit seen18;
            rst = 1'b1;
            jal_mode = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            id_ready = 1'b1;
            v2_at10 = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (id_valid) begin
                    pcs.push_back(id_pc);
                    if (id_pc == 32'h10) v2_at10 = id_valid2;
                end
                @(posedge clk);
                #1;
            end
            idx = -1;
            seen18 = 1'b0;
            for (int i = 0; i < pcs.size(); i++) begin
                if (pcs[i] == 32'h10 && idx < 0) idx = i;
                if (pcs[i] == 32'h18) seen18 = 1'b1;
            end
            check("jal_seen", 32'(idx >= 0 && idx + 1 < pcs.size()), 32'd1);
            check("jal_valid2", 32'(v2_at10), 32'd0);
            check("jal_target", (idx >= 0 && idx + 1 < pcs.size()) ? pcs[idx+1] : 32'hFFFF_FFFF, 32'h20);
            check("jal_squash", 32'(seen18), 32'd0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
